// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses program memory and registers the fetched
// word into the IR, with stall/replay/hold from stall control and jump flush.
module instruction_fetch_unit #(
  parameter int              AW  = 8,
  parameter int              IW  = 32,
  parameter logic [IW-1:0]   NOP = {IW{1'b0}},
  parameter int              SCW = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           stall_pm,
  input  logic           jmp_en,
  input  logic [AW-1:0]  jmp_addr,
  output logic [AW-1:0]  pm_addr,
  input  logic [IW-1:0]  pm_data,
  output logic [IW-1:0]  ins,
  output logic [AW-1:0]  ins_pc,
  output logic [5:0]     op,
  output logic           ins_valid,
  output logic [SCW-1:0] stall_cnt
);

  typedef struct packed {
    logic [IW-1:0] ins;
    logic [AW-1:0] pc;
    logic          valid;
  } ir_t;

  logic [AW-1:0] pc, pc_nxt;
  ir_t           ir, ir_nxt;

  // Jump beats stall for the PC; a stall with no jump replays the same fetch.
  always_comb begin
    pc_nxt = pc + 1'b1;
    if (jmp_en)     pc_nxt = jmp_addr;
    else if (stall) pc_nxt = pc;
  end

  // Flush wins over hold so a redirect never leaves a stale word in the IR.
  always_comb begin
    ir_nxt = ir;
    if (jmp_en) begin
      ir_nxt.ins   = NOP;
      ir_nxt.pc    = jmp_addr;
      ir_nxt.valid = 1'b0;
    end else if (!stall_pm) begin
      ir_nxt.ins   = pm_data;
      ir_nxt.pc    = pc;
      ir_nxt.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      ir.ins    <= NOP;
      ir.pc     <= '0;
      ir.valid  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      pc <= pc_nxt;
      ir <= ir_nxt;
      if (stall && stall_cnt != {SCW{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign pm_addr   = pc;
  assign ins       = ir.ins;
  assign ins_pc    = ir.pc;
  assign ins_valid = ir.valid;
  assign op        = ir.ins[IW-1 -: 6];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + randomized bench for instruction_fetch_unit against a spec-level
// model; a second instance with a 4-bit stall counter covers saturation.
module tb_instruction_fetch_unit;
  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0, stall_pm = 1'b0, jmp_en = 1'b0;
  logic [AW-1:0] jmp_addr = '0;

  logic [AW-1:0] pm_addr, ins_pc, pm_addr4, ins_pc4;
  logic [IW-1:0] pm_data, ins, pm_data4, ins4;
  logic [5:0]    op, op4;
  logic          ins_valid, ins_valid4;
  logic [15:0]   stall_cnt;
  logic [3:0]    stall_cnt4;

  logic [IW-1:0] mem [256];
  assign pm_data  = mem[pm_addr];
  assign pm_data4 = mem[pm_addr4];

  always #5 clk = ~clk;

  instruction_fetch_unit u_dut (
    .clk(clk), .reset(reset), .stall(stall), .stall_pm(stall_pm),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr), .pm_addr(pm_addr), .pm_data(pm_data),
    .ins(ins), .ins_pc(ins_pc), .op(op), .ins_valid(ins_valid), .stall_cnt(stall_cnt)
  );

  instruction_fetch_unit #(.SCW(4)) u_sat (
    .clk(clk), .reset(reset), .stall(stall), .stall_pm(stall_pm),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr), .pm_addr(pm_addr4), .pm_data(pm_data4),
    .ins(ins4), .ins_pc(ins_pc4), .op(op4), .ins_valid(ins_valid4), .stall_cnt(stall_cnt4)
  );

  // Reference state, kept as plain integers.
  int          m_pc, m_ins_pc, m_cnt, m_cnt4;
  logic [31:0] m_ins;
  bit          m_valid;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ins = 32'h0; m_ins_pc = 0; m_valid = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    64'(pm_addr),    64'(m_pc));
    chk({tag, ".ins"},   64'(ins),        64'(m_ins));
    chk({tag, ".ipc"},   64'(ins_pc),     64'(m_ins_pc));
    chk({tag, ".vld"},   64'(ins_valid),  64'(m_valid));
    chk({tag, ".op"},    64'(op),         64'(m_ins >> 26));
    chk({tag, ".cnt"},   64'(stall_cnt),  64'(m_cnt));
    chk({tag, ".cnt4"},  64'(stall_cnt4), 64'(m_cnt4));
    chk({tag, ".ins4"},  64'(ins4),       64'(m_ins));
  endtask

  // Drive one cycle's controls, advance the model across the edge, then check.
  task automatic step(input string tag, input bit j, input bit s, input bit p,
                      input int a);
    logic [31:0] fetched;
    jmp_en = j; stall = s; stall_pm = p; jmp_addr = 8'(a);
    @(posedge clk);
    fetched = mem[m_pc];
    if (s) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (j) begin
      m_ins = 32'h0; m_valid = 0; m_ins_pc = a;
    end else if (!p) begin
      m_ins = fetched; m_valid = 1; m_ins_pc = m_pc;
    end
    if (j)       m_pc = a;
    else if (!s) m_pc = (m_pc + 1) % 256;
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {i[5:0], 18'h0, i[7:0]};
    #1 reset = 1'b0;
    #2 model_reset();
    check_all("reset");

    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) step("run", 0, 0, 0, 0);

    step("wrap_jmp", 1, 0, 0, 8'hFE);
    for (int i = 0; i < 3; i++) step("wrap", 0, 0, 0, 0);
    chk("wrap_pc01", 64'(pm_addr), 64'h01);

    step("to4", 1, 0, 0, 4);
    step("at5", 0, 0, 0, 0);
    step("stall1", 0, 1, 0, 0);
    step("stall2", 0, 1, 0, 0);
    chk("stall_ipc5", 64'(ins_pc), 64'd5);
    step("unstall", 0, 0, 0, 0);
    chk("stall_pc6", 64'(pm_addr), 64'd6);

    mem[6] = 32'h12345678;
    step("load_k", 0, 0, 0, 0);
    mem[7] = 32'hCAFEF00D;
    step("spm_hold", 0, 0, 1, 0);
    chk("spm_ins", 64'(ins), 64'h12345678);
    mem[8] = 32'h0BADBEEF;
    step("spm_rel", 0, 0, 0, 0);

    step("prio", 1, 1, 1, 8'h40);

    // HLT in the IR: act as stall control and keep stall high until a jump.
    mem[8'h50] = {6'b010001, 26'h1234};
    step("hlt_jmp", 1, 0, 0, 8'h50);
    step("hlt_fetch", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("hlt_hold", 0, (op == 6'b010001), 0, 0);
    step("hlt_exit", 1, 1, 0, 8'h10);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 255)] = $urandom;
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 255));
    end

    for (int i = 0; i < 20; i++) step("sat", 0, 1, 0, 0);
    chk("sat15", 64'(stall_cnt4), 64'd15);

    step("to33", 1, 0, 0, 8'h32);
    step("at33", 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk) reset = 1'b1;
    step("post_rst", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
